// File: rtl/led_cmd_ctrl.sv
// rtl/led_cmd_ctrl.sv - UART single-character command decoder driving the blinker enable.
// Accepts one command per response handshake; a 'P' pulse timer runs independently of the FSM.
module led_cmd_ctrl #(
   parameter logic [31:0] CLOCK_FREQUENCY = 32'd33_000_000,
   parameter logic [31:0] PULSE_MS        = 32'd1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic       blink_enable,
   output logic       pulse_active,
   output logic       overrun
);

   localparam logic [31:0] PULSE_CYCLES = (CLOCK_FREQUENCY / 32'd1000) * PULSE_MS;

   typedef enum logic {IDLE, RESP} state_t;

   state_t      state, state_next;
   logic [31:0] count, count_next;
   logic        blink_next, pulse_next, tx_valid_next, overrun_next;
   logic [7:0]  tx_data_next;
   logic        expire;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         count        <= 32'd0;
         blink_enable <= 1'b0;
         pulse_active <= 1'b0;
         tx_valid     <= 1'b0;
         tx_data      <= 8'h00;
         overrun      <= 1'b0;
      end else begin
         state        <= state_next;
         count        <= count_next;
         blink_enable <= blink_next;
         pulse_active <= pulse_next;
         tx_valid     <= tx_valid_next;
         tx_data      <= tx_data_next;
         overrun      <= overrun_next;
      end
   end

   assign expire = pulse_active && (count == PULSE_CYCLES - 32'd1);

   always_comb begin
      state_next    = state;
      blink_next    = blink_enable;
      pulse_next    = pulse_active;
      count_next    = pulse_active ? count + 32'd1 : count;
      tx_valid_next = tx_valid;
      tx_data_next  = tx_data;
      overrun_next  = 1'b0;

      // Expiry is applied first so that a command accepted on the same edge overrides it.
      if (expire) begin
         blink_next = 1'b0;
         pulse_next = 1'b0;
         count_next = 32'd0;
      end

      case (state)
         IDLE: begin
            if (rx_valid) begin
               state_next    = RESP;
               tx_valid_next = 1'b1;
               tx_data_next  = 8'h4B;
               case (rx_data)
                  8'h31: begin
                     blink_next = 1'b1;
                     pulse_next = 1'b0;
                     count_next = 32'd0;
                  end
                  8'h30: begin
                     blink_next = 1'b0;
                     pulse_next = 1'b0;
                     count_next = 32'd0;
                  end
                  8'h54: begin
                     blink_next = ~blink_enable;
                     pulse_next = 1'b0;
                     count_next = 32'd0;
                  end
                  8'h50: begin
                     blink_next = 1'b1;
                     pulse_next = 1'b1;
                     count_next = 32'd0;
                  end
                  8'h3F:   tx_data_next = blink_enable ? 8'h31 : 8'h30;
                  default: tx_data_next = 8'h45;
               endcase
            end
         end
         RESP: begin
            // Bytes arriving while a response is outstanding are dropped, handshake edge included.
            overrun_next = rx_valid;
            if (tx_ready) begin
               state_next    = IDLE;
               tx_valid_next = 1'b0;
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule
